// File: rtl/merge_pair_arbiter_pkg.sv
// Shared types and helpers for the merge-pair arbiter: FSM state encoding,
// beat-width derivation and run-terminator detection.
package merge_pair_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } arb_state_t;

    localparam int TUPLES_PER_BEAT = 16;
    // Widest tuple the terminator check supports; callers zero-extend tuple 0.
    localparam int MAX_TUPLE_W     = 1024;

    function automatic int beat_width(input int data_width);
        return TUPLES_PER_BEAT * data_width;
    endfunction

    // A beat ends a sorted run when its first tuple is all zeros.
    function automatic logic is_terminator(input logic [MAX_TUPLE_W-1:0] tuple0);
        return (tuple0 == '0);
    endfunction

endpackage

// File: rtl/merge_pair_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after i_ptr,
// wrapping modulo NUM_REQ.
module merge_pair_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [IW-1:0]      o_idx
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_idx   = '0;
        // Walk from farthest to nearest so the slot closest to i_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/merge_pair_arbiter.sv
// Time-shares one merger between NUM_PAIRS FIFO pairs, one whole run per
// grant, rotating round-robin once the merger's output terminator is seen.
module merge_pair_arbiter
    import merge_pair_arbiter_pkg::*;
#(
    parameter  int NUM_PAIRS  = 4,
    parameter  int DATA_WIDTH = 128,
    parameter  int KEY_WIDTH  = 80,
    localparam int W          = beat_width(DATA_WIDTH),
    localparam int GW         = $clog2(NUM_PAIRS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_PAIRS*W-1:0] i_pair_data_1,
    input  logic [NUM_PAIRS-1:0]   i_pair_empty_1,
    input  logic [NUM_PAIRS*W-1:0] i_pair_data_2,
    input  logic [NUM_PAIRS-1:0]   i_pair_empty_2,
    output logic [NUM_PAIRS-1:0]   o_pair_read_1,
    output logic [NUM_PAIRS-1:0]   o_pair_read_2,
    output logic [W-1:0]           o_fifo_1,
    output logic                   o_fifo_1_empty,
    output logic [W-1:0]           o_fifo_2,
    output logic                   o_fifo_2_empty,
    input  logic                   i_fifo_1_read,
    input  logic                   i_fifo_2_read,
    input  logic                   i_out_write,
    input  logic [W-1:0]           i_out_data,
    output logic [GW-1:0]          o_grant,
    output logic                   o_busy,
    output logic [15:0]            o_runs_done
);

    arb_state_t    r_state, w_state_nx;
    logic [GW-1:0] r_grant, r_rr_ptr, w_grant_inc;
    logic          r_done_1, r_done_2, r_out_done;
    logic [15:0]   r_runs_done;

    logic [NUM_PAIRS-1:0]        w_req;
    logic                        w_pick_vld;
    logic [GW-1:0]               w_pick_idx;
    logic [NUM_PAIRS-1:0][W-1:0] w_d1, w_d2;
    logic [W-1:0]                w_head_1, w_head_2;
    logic w_busy, w_stream, w_emp_1, w_emp_2, w_rd_1, w_rd_2;
    logic w_term_1, w_term_2, w_out_term;
    logic w_done_1_nx, w_done_2_nx, w_out_done_nx, w_run_end;
    logic w_unused;

    assign w_req = ~i_pair_empty_1 & ~i_pair_empty_2;

    merge_pair_arbiter_rr_pick #(.NUM_REQ(NUM_PAIRS)) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_d1     = i_pair_data_1;
    assign w_d2     = i_pair_data_2;
    assign w_head_1 = w_d1[r_grant];
    assign w_head_2 = w_d2[r_grant];

    // Routing is live only while streaming; a reset cycle issues no strobes.
    assign w_busy   = (r_state != ST_IDLE);
    assign w_stream = (r_state == ST_STREAM) && !i_rst;
    assign w_emp_1  = !w_stream || i_pair_empty_1[r_grant] || r_done_1;
    assign w_emp_2  = !w_stream || i_pair_empty_2[r_grant] || r_done_2;
    assign w_rd_1   = i_fifo_1_read && !w_emp_1;
    assign w_rd_2   = i_fifo_2_read && !w_emp_2;

    assign w_term_1   = w_rd_1 && is_terminator(MAX_TUPLE_W'(w_head_1[DATA_WIDTH-1:0]));
    assign w_term_2   = w_rd_2 && is_terminator(MAX_TUPLE_W'(w_head_2[DATA_WIDTH-1:0]));
    assign w_out_term = w_busy && i_out_write &&
                        is_terminator(MAX_TUPLE_W'(i_out_data[DATA_WIDTH-1:0]));

    assign w_grant_inc = (r_grant == GW'(NUM_PAIRS - 1)) ? '0 : r_grant + GW'(1);

    always_comb begin
        w_state_nx    = r_state;
        w_done_1_nx   = r_done_1 | w_term_1;
        w_done_2_nx   = r_done_2 | w_term_2;
        w_out_done_nx = r_out_done | w_out_term;
        w_run_end     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) w_state_nx = ST_STREAM;
            end
            ST_STREAM, ST_DRAIN: begin
                // Output terminator may arrive early; exit as soon as all three agree.
                if (w_done_1_nx && w_done_2_nx) begin
                    if (w_out_done_nx) begin
                        w_run_end  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_DRAIN;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_done_1    <= 1'b0;
            r_done_2    <= 1'b0;
            r_out_done  <= 1'b0;
            r_runs_done <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ST_IDLE && w_pick_vld) r_grant <= w_pick_idx;
            if (w_run_end) begin
                r_done_1    <= 1'b0;
                r_done_2    <= 1'b0;
                r_out_done  <= 1'b0;
                r_rr_ptr    <= w_grant_inc;
                r_runs_done <= r_runs_done + 16'd1;
            end else begin
                r_done_1   <= w_done_1_nx;
                r_done_2   <= w_done_2_nx;
                r_out_done <= w_out_done_nx;
            end
        end
    end

    assign o_fifo_1       = w_head_1;
    assign o_fifo_2       = w_head_2;
    assign o_fifo_1_empty = w_emp_1;
    assign o_fifo_2_empty = w_emp_2;
    assign o_pair_read_1  = w_rd_1 ? (NUM_PAIRS'(1) << r_grant) : '0;
    assign o_pair_read_2  = w_rd_2 ? (NUM_PAIRS'(1) << r_grant) : '0;
    assign o_grant        = r_grant;
    assign o_busy         = w_busy;
    assign o_runs_done    = r_runs_done;

    // Only tuple 0 of the output beat matters here; keys are never compared.
    assign w_unused = ^{i_out_data[W-1:DATA_WIDTH], KEY_WIDTH > 0};

endmodule

// File: tb/tb_merge_pair_arbiter.sv
// Scoreboard bench: stimulus loads FIFO models and queues expected reads,
// grants and run counts; a negedge monitor pops and compares.
module tb_merge_pair_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int W  = 16 * DW;
    localparam int GW = $clog2(NP);
    localparam int C_DRAIN = 0, C_BUSY = 1, C_Q1 = 2, C_Q2 = 3;

    typedef logic [W-1:0] beat_t;
    typedef struct {
        int    p;
        beat_t d;
    } rd_exp_t;

    logic            clk = 1'b0, rst = 1'b1;
    logic [NP*W-1:0] pd1, pd2;
    logic [NP-1:0]   pe1, pe2, rd1, rd2;
    beat_t           f1, f2, od = '0;
    logic            f1e, f2e, mr1 = 1'b0, mr2 = 1'b0, ow = 1'b0;
    logic [GW-1:0]   grant;
    logic            busy;
    logic [15:0]     runs;

    merge_pair_arbiter #(.NUM_PAIRS(NP), .DATA_WIDTH(DW), .KEY_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pair_data_1(pd1), .i_pair_empty_1(pe1),
        .i_pair_data_2(pd2), .i_pair_empty_2(pe2),
        .o_pair_read_1(rd1), .o_pair_read_2(rd2),
        .o_fifo_1(f1), .o_fifo_1_empty(f1e),
        .o_fifo_2(f2), .o_fifo_2_empty(f2e),
        .i_fifo_1_read(mr1), .i_fifo_2_read(mr2),
        .i_out_write(ow), .i_out_data(od),
        .o_grant(grant), .o_busy(busy), .o_runs_done(runs)
    );

    always #5 clk = ~clk;

    beat_t       fq1[NP][$];
    beat_t       fq2[NP][$];
    rd_exp_t     exp1[$];
    rd_exp_t     exp2[$];
    int          exp_g[$];
    int          exp_r[$];
    int          n_chk = 0, n_fail = 0, runs_cnt = 0;
    logic        mon_en = 1'b0, prev_busy = 1'b0;
    logic [15:0] prev_runs = '0;
    logic [NP-1:0] lat1 = '0, lat2 = '0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic drive_fifos();
        for (int p = 0; p < NP; p++) begin
            pe1[p] = (fq1[p].size() == 0);
            pe2[p] = (fq2[p].size() == 0);
            pd1[p*W +: W] = pe1[p] ? '0 : fq1[p][0];
            pd2[p*W +: W] = pe2[p] ? '0 : fq2[p][0];
        end
    endtask

    function automatic beat_t mk(input int tag, input int t0);
        beat_t b;
        b = '0;
        b[W-1:DW] = (W-DW)'(tag);
        b[DW-1:0] = DW'(t0);
        return b;
    endfunction

    // n data beats then a terminator into one side of pair p; expected reads follow.
    task automatic load(input int p, input int side, input int n, input int tag);
        rd_exp_t e;
        for (int k = 0; k <= n; k++) begin
            e.p = p;
            e.d = mk(tag * 16 + k, (k == n) ? 0 : k + 1);
            if (side == 1) begin fq1[p].push_back(e.d); exp1.push_back(e); end
            else           begin fq2[p].push_back(e.d); exp2.push_back(e); end
        end
        drive_fifos();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic cond(input int what);
        case (what)
            C_DRAIN: return busy && f1e && f2e;
            C_BUSY:  return busy;
            C_Q1:    return exp1.size() == 0;
            default: return exp2.size() == 0;
        endcase
    endfunction

    task automatic wait_for(input int what, input string nm);
        int k;
        k = 0;
        while (!cond(what) && k < 300) begin tick(); k++; end
        if (k >= 300) chk({nm, "_timeout"}, W'(k), '0);
    endtask

    task automatic send_term(input int tag);
        ow = 1'b1;
        od = mk(tag, 0);
        runs_cnt++;
        exp_r.push_back(runs_cnt);
        tick();
        ow = 1'b0;
        od = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if (runs_cnt != 0) exp_r.push_back(0);
        runs_cnt = 0;
        #1;
        chk("rst_cycle_strobes", W'({rd1, rd2}), '0);
        tick();
        rst = 1'b0;
    endtask

    // FIFO model: pop whatever the DUT strobed in the cycle just ended.
    initial forever begin
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (lat1[p] && fq1[p].size() > 0) fq1[p].delete(0);
            if (lat2[p] && fq2[p].size() > 0) fq2[p].delete(0);
        end
        drive_fifos();
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            if (rd1 != '0) begin
                if (exp1.size() == 0) chk("rd1_unexpected", W'(rd1), '0);
                else begin
                    e = exp1.pop_front();
                    chk("rd1_sel", W'(rd1), W'(1) << e.p);
                    chk("rd1_data", f1, e.d);
                end
            end
            if (rd2 != '0) begin
                if (exp2.size() == 0) chk("rd2_unexpected", W'(rd2), '0);
                else begin
                    e = exp2.pop_front();
                    chk("rd2_sel", W'(rd2), W'(1) << e.p);
                    chk("rd2_data", f2, e.d);
                end
            end
            if (busy && !prev_busy) begin
                if (exp_g.size() == 0) chk("grant_unexpected", W'(busy), '0);
                else chk("grant", W'(grant), W'(exp_g.pop_front()));
            end
            if (runs != prev_runs) begin
                if (exp_r.size() == 0) chk("runs_unexpected", W'(runs), W'(prev_runs));
                else chk("runs_done", W'(runs), W'(exp_r.pop_front()));
            end
            prev_busy = busy;
            prev_runs = runs;
        end
        lat1 = rd1;
        lat2 = rd2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        drive_fifos();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_busy", W'(busy), '0);
        chk("rst_empties", W'({f1e, f2e}), W'(2'b11));
        chk("rst_strobes", W'({rd1, rd2}), '0);
        chk("rst_grant", W'(grant), '0);
        chk("rst_runs", W'(runs), '0);
        prev_busy = busy;
        prev_runs = runs;
        mon_en = 1'b1;

        // Single ready pair 2, equal-length runs: both terminators land together.
        mr1 = 1'b1; mr2 = 1'b1;
        load(2, 1, 3, 1); load(2, 2, 3, 2);
        exp_g.push_back(2);
        wait_for(C_DRAIN, "t1");
        for (int i = 0; i < 5; i++) begin
            chk("t1_drain_busy", W'(busy), W'(1));
            chk("t1_drain_empties", W'({f1e, f2e}), W'(2'b11));
            chk("t1_drain_strobes", W'({rd1, rd2}), '0);
            ow = (i == 2);
            od = (i == 2) ? mk(99, 5) : '0;
            tick();
        end
        send_term(7);
        chk("t1_idle_after_run", W'(busy), '0);

        // Pairs 0,1,3 all ready with pair 0 holding two runs: 0,1,3,0.
        do_reset();
        load(0, 1, 1, 10); load(0, 2, 2, 11);
        load(1, 1, 0, 12); load(1, 2, 1, 13);
        load(3, 1, 3, 14); load(3, 2, 0, 15);
        load(0, 1, 1, 16); load(0, 2, 1, 17);
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(3); exp_g.push_back(0);
        for (int r = 0; r < 4; r++) begin
            wait_for(C_DRAIN, "t2");
            send_term(20 + r);
        end
        chk("t2_idle", W'(busy), '0);

        // Side 1 ends early with the next run queued behind it.
        load(1, 1, 1, 30); load(1, 2, 3, 31);
        load(1, 1, 1, 32); load(1, 2, 1, 33);
        exp_g.push_back(1); exp_g.push_back(1);
        k = 0;
        while (!cond(C_DRAIN) && k < 300) begin
            if (busy && exp1.size() == 2) chk("t3_side1_held_empty", W'(f1e), W'(1));
            tick();
            k++;
        end
        if (k >= 300) chk("t3_timeout", W'(k), '0);
        send_term(34);
        wait_for(C_DRAIN, "t3b");
        send_term(35);

        // Output terminator arrives before either input side is done.
        mr1 = 1'b0; mr2 = 1'b0;
        load(3, 1, 2, 40); load(3, 2, 2, 41);
        exp_g.push_back(3);
        wait_for(C_BUSY, "t5");
        send_term(42);
        chk("t5_hold_busy", W'(busy), W'(1));
        mr1 = 1'b1;
        wait_for(C_Q1, "t5a");
        tick();
        chk("t5_one_side_busy", W'(busy), W'(1));
        chk("t5_side1_empty", W'(f1e), W'(1));
        mr2 = 1'b1;
        wait_for(C_Q2, "t5b");
        chk("t5_exit_same_cycle", W'(busy), '0);
        chk("t5_idle_empty", W'(f2e), W'(1));

        // Reset mid-run; the pair is re-granted and finishes afterwards.
        load(0, 1, 6, 50); load(0, 2, 6, 51);
        exp_g.push_back(0); exp_g.push_back(0);
        wait_for(C_BUSY, "t6");
        tick(); tick();
        do_reset();
        chk("t6_busy", W'(busy), '0);
        chk("t6_empties", W'({f1e, f2e}), W'(2'b11));
        chk("t6_strobes", W'({rd1, rd2}), '0);
        chk("t6_grant", W'(grant), '0);
        chk("t6_runs", W'(runs), '0);
        wait_for(C_DRAIN, "t6b");
        send_term(52);
        chk("t6_idle", W'(busy), '0);

        tick();
        chk("end_exp1_left", W'(exp1.size()), '0);
        chk("end_exp2_left", W'(exp2.size()), '0);
        chk("end_grants_left", W'(exp_g.size()), '0);
        chk("end_runs_left", W'(exp_r.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
